// File: rtl/motoro3_ramp_controller.sv
// Speed sequencer for the motoro3 step generator: start at MIN_FREQ, ramp to target, ramp down to stop.
// Optional stall watchdog enabled by defining MOTORO3_WDOG_EN.
module motoro3_ramp_controller #(
  parameter logic [9:0]  MIN_FREQ  = 10'd16,
  parameter logic [9:0]  RAMP_STEP = 10'd4,
  parameter int unsigned RAMP_DIV  = 8,
  parameter logic [23:0] WDOG_CYC  = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       runReq,
  input  logic [9:0] tgtFreq,
  input  logic       m3cntLast1,
  output logic       m3start,
  output logic [9:0] m3freq,
  output logic       busy,
  output logic       atSpeed,
  output logic [2:0] ctrlState,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_RUN       = 3'd3,
    ST_RAMP_DOWN = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_freq, w_freq_nxt;
  logic [7:0]  r_div, w_div_nxt;
  logic        r_m3start, w_m3start_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_atSpeed, w_atSpeed_nxt;
  logic        r_fault, w_fault_nxt;

  logic [9:0]  w_tgtE;
  logic        w_divActive;
  logic        w_tick;
  logic        w_stall;
  logic [10:0] w_upSum;
  logic [9:0]  w_upSat;
  logic [9:0]  w_upVal;
  logic [9:0]  w_floor;
  logic [9:0]  w_dnRaw;
  logic [9:0]  w_dnVal;

  assign w_tgtE      = (tgtFreq < MIN_FREQ) ? MIN_FREQ : tgtFreq;
  assign w_divActive = (r_state == ST_START) || (r_state == ST_RAMP_UP) ||
                       (r_state == ST_RUN)   || (r_state == ST_RAMP_DOWN);
  assign w_tick      = w_divActive && m3cntLast1 && (r_div == 8'(RAMP_DIV - 1));

  assign w_upSum = {1'b0, r_freq} + {1'b0, RAMP_STEP};
  assign w_upSat = w_upSum[10] ? 10'h3FF : w_upSum[9:0];
  assign w_upVal = (w_upSat > w_tgtE) ? w_tgtE : w_upSat;
  assign w_floor = runReq ? w_tgtE : MIN_FREQ;
  assign w_dnRaw = (r_freq >= RAMP_STEP) ? (r_freq - RAMP_STEP) : '0;
  assign w_dnVal = (w_dnRaw < w_floor) ? w_floor : w_dnRaw;

`ifdef MOTORO3_WDOG_EN
  logic [23:0] r_wdog;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wdog <= '0;
    end else if (!r_m3start || m3cntLast1) begin
      r_wdog <= '0;
    end else if (r_wdog != WDOG_CYC) begin
      r_wdog <= r_wdog + 24'd1;
    end
  end

  assign w_stall = (r_wdog == WDOG_CYC);
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_freq_nxt  = r_freq;
    w_fault_nxt = r_fault;
    w_div_nxt   = r_div;

    case (r_state)
      ST_IDLE: begin
        w_freq_nxt = MIN_FREQ;
        if (!runReq) begin
          w_fault_nxt = 1'b0;
        end else if (!r_fault) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_freq_nxt = MIN_FREQ;
        if (!runReq) begin
          w_state_nxt = ST_IDLE;
        end else if (m3cntLast1) begin
          w_state_nxt = (w_tgtE == MIN_FREQ) ? ST_RUN : ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        // Only step up while the target is still above; a lowered target is ramped down instead.
        if (w_tick && (w_tgtE > r_freq)) begin
          w_freq_nxt = w_upVal;
        end
        if (!runReq) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (w_freq_nxt == w_tgtE) begin
          w_state_nxt = ST_RUN;
        end else if (w_tgtE < w_freq_nxt) begin
          w_state_nxt = ST_RAMP_DOWN;
        end
      end
      ST_RUN: begin
        if (!runReq) begin
          w_state_nxt = ST_RAMP_DOWN;
        end else if (w_tgtE > r_freq) begin
          w_state_nxt = ST_RAMP_UP;
        end else if (w_tgtE < r_freq) begin
          w_state_nxt = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        // A floor above the current speed is reached at once; RUN then ramps up.
        if (w_tick && (r_freq > w_floor)) begin
          w_freq_nxt = w_dnVal;
        end
        if (w_freq_nxt <= w_floor) begin
          w_state_nxt = runReq ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_freq_nxt  = MIN_FREQ;
      end
    endcase

    if (w_stall) begin
      w_state_nxt = ST_IDLE;
      w_freq_nxt  = MIN_FREQ;
      w_fault_nxt = 1'b1;
    end

    if (w_state_nxt == ST_IDLE) begin
      w_div_nxt = '0;
    end else if (w_divActive && m3cntLast1) begin
      w_div_nxt = w_tick ? 8'd0 : (r_div + 8'd1);
    end

    w_m3start_nxt = (w_state_nxt != ST_IDLE);
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_atSpeed_nxt = (w_state_nxt == ST_RUN) && (w_freq_nxt == w_tgtE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= ST_IDLE;
      r_freq    <= MIN_FREQ;
      r_div     <= '0;
      r_m3start <= 1'b0;
      r_busy    <= 1'b0;
      r_atSpeed <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_freq    <= w_freq_nxt;
      r_div     <= w_div_nxt;
      r_m3start <= w_m3start_nxt;
      r_busy    <= w_busy_nxt;
      r_atSpeed <= w_atSpeed_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  assign m3start   = r_m3start;
  assign m3freq    = r_freq;
  assign busy      = r_busy;
  assign atSpeed   = r_atSpeed;
  assign ctrlState = r_state;
  assign fault     = r_fault;

endmodule

// File: tb/tb_motoro3_ramp_controller.sv
// Scoreboard bench for motoro3_ramp_controller: expected output snapshots are queued by the stimulus
// and checked, with optional exact cycle spacing, whenever any output changes.
module tb_motoro3_ramp_controller;

  localparam int P = 10;  // m3cntLast1 period in clk cycles; RAMP_DIV=2 gives a tick every 20

  logic       clk = 1'b0;
  logic       nRst;
  logic       runReq;
  logic [9:0] tgtFreq;
  logic       m3cntLast1;
  logic       m3start;
  logic [9:0] m3freq;
  logic       busy;
  logic       atSpeed;
  logic [2:0] ctrlState;
  logic       fault;

  int total = 0;
  int bad   = 0;
  bit pulse_en = 1'b0;

  typedef struct {
    string       tag;
    logic [16:0] v;
    int          gap;
  } exp_t;

  exp_t sb[$];

  motoro3_ramp_controller #(
    .MIN_FREQ (10'd16),
    .RAMP_STEP(10'd4),
    .RAMP_DIV (2),
    .WDOG_CYC (24'd1000)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .runReq    (runReq),
    .tgtFreq   (tgtFreq),
    .m3cntLast1(m3cntLast1),
    .m3start   (m3start),
    .m3freq    (m3freq),
    .busy      (busy),
    .atSpeed   (atSpeed),
    .ctrlState (ctrlState),
    .fault     (fault)
  );

  initial forever #5 clk = ~clk;

  function automatic string fmt(logic [16:0] v);
    return $sformatf("st=%0d f=%0d start=%0b busy=%0b at=%0b flt=%0b",
                     v[16:14], v[13:4], v[3], v[2], v[1], v[0]);
  endfunction

  // m3start and busy are both 1 in every state except IDLE.
  function automatic void push_exp(string tag, int st, int f, bit at, bit flt, int gap);
    exp_t e;
    e.tag = tag;
    e.v   = {3'(st), 10'(f), (st != 0), (st != 0), at, flt};
    e.gap = gap;
    sb.push_back(e);
  endfunction

  task automatic drain(int budget);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sb.size() != 0 && n < budget);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d events still pending after %0d cycles, required 0", sb.size(), n);
      sb.delete();
    end
    #1;
  endtask

  // Step generator stand-in: one-cycle pulse every P cycles, free-running so tick spacing is exact.
  initial begin
    int pcnt = 0;
    m3cntLast1 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pulse_en) begin
        pcnt++;
        if (pcnt == P) begin
          m3cntLast1 = 1'b1;
          pcnt = 0;
        end else begin
          m3cntLast1 = 1'b0;
        end
      end else begin
        m3cntLast1 = 1'b0;
      end
    end
  end

  // Monitor: every change of the output tuple consumes one expected snapshot.
  initial begin
    logic [16:0] prev;
    logic [16:0] cur;
    exp_t        e;
    int          cyc  = 0;
    int          last = 0;
    prev = 'x;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {ctrlState, m3freq, m3start, busy, atSpeed, fault};
      if (cur !== prev) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: got %s, required no change", fmt(cur));
        end else begin
          e = sb.pop_front();
          if (cur !== e.v) begin
            bad++;
            $display("FAIL %s: got %s, required %s", e.tag, fmt(cur), fmt(e.v));
          end
          if (e.gap != 0) begin
            total++;
            if (cyc - last != e.gap) begin
              bad++;
              $display("FAIL %s_gap: got %0d cycles, required %0d", e.tag, cyc - last, e.gap);
            end
          end
        end
        prev = cur;
        last = cyc;
      end
    end
  end

  initial begin
    nRst    = 1'b1;
    runReq  = 1'b0;
    tgtFreq = 10'd40;
    push_exp("reset", 0, 16, 0, 0, 0);
    #1 nRst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;
    pulse_en = 1'b1;
    drain(10);

    // Ramp up 16 -> 40; first tick comes one pulse after START's pulse.
    push_exp("start", 1, 16, 0, 0, 0);
    push_exp("up_entry", 2, 16, 0, 0, 0);
    push_exp("up20", 2, 20, 0, 0, 10);
    for (int v = 24; v <= 36; v += 4) push_exp("up", 2, v, 0, 0, 20);
    push_exp("run40", 3, 40, 1, 0, 20);
    runReq = 1'b1;
    drain(400);

    // Retarget down to 24.
    push_exp("rt_down_entry", 4, 40, 0, 0, 0);
    push_exp("rt_dn36", 4, 36, 0, 0, 0);
    push_exp("rt_dn32", 4, 32, 0, 0, 20);
    push_exp("rt_dn28", 4, 28, 0, 0, 20);
    push_exp("rt_run24", 3, 24, 1, 0, 20);
    tgtFreq = 10'd24;
    drain(400);

    // Retarget up to 32 through RAMP_UP.
    push_exp("rt_up_entry", 2, 24, 0, 0, 0);
    push_exp("rt_up28", 2, 28, 0, 0, 0);
    push_exp("rt_run32", 3, 32, 1, 0, 20);
    tgtFreq = 10'd32;
    drain(400);

    // Stop ramp, then runReq back high at 28 with target 24: lands in RUN, no IDLE.
    push_exp("stop_entry", 4, 32, 0, 0, 0);
    push_exp("stop28", 4, 28, 0, 0, 0);
    runReq = 1'b0;
    drain(400);
    push_exp("rerun24", 3, 24, 1, 0, 20);
    tgtFreq = 10'd24;
    runReq  = 1'b1;
    drain(400);

    // Stop ramp, then runReq back high at 20 with target 40: RUN then RAMP_UP.
    push_exp("stop2_entry", 4, 24, 0, 0, 0);
    push_exp("stop2_20", 4, 20, 0, 0, 0);
    runReq = 1'b0;
    drain(400);
    push_exp("below_floor_run", 3, 20, 0, 0, 0);
    push_exp("below_floor_up", 2, 20, 0, 0, 1);
    push_exp("reup24", 2, 24, 0, 0, 0);
    for (int v = 28; v <= 36; v += 4) push_exp("reup", 2, v, 0, 0, 20);
    push_exp("reup_run40", 3, 40, 1, 0, 20);
    tgtFreq = 10'd40;
    runReq  = 1'b1;
    drain(400);

    // Full ramp down to stop.
    push_exp("dn_entry", 4, 40, 0, 0, 0);
    push_exp("dn36", 4, 36, 0, 0, 0);
    for (int v = 32; v >= 20; v -= 4) push_exp("dn", 4, v, 0, 0, 20);
    push_exp("dn_idle", 0, 16, 0, 0, 20);
    runReq = 1'b0;
    drain(400);

    // Target below MIN_FREQ: START goes straight to RUN at 16; stop is immediate.
    push_exp("low_start", 1, 16, 0, 0, 0);
    push_exp("low_run16", 3, 16, 1, 0, 0);
    tgtFreq = 10'd5;
    runReq  = 1'b1;
    drain(100);
    push_exp("low_down", 4, 16, 0, 0, 0);
    push_exp("low_idle", 0, 16, 0, 0, 1);
    runReq = 1'b0;
    drain(100);

    // Full-scale target: last up step clamps 1020 -> 1023; last down step clamps 19 -> 16.
    push_exp("max_start", 1, 16, 0, 0, 0);
    push_exp("max_up_entry", 2, 16, 0, 0, 0);
    push_exp("max_up20", 2, 20, 0, 0, 10);
    for (int v = 24; v <= 1020; v += 4) push_exp("max_up", 2, v, 0, 0, 20);
    push_exp("max_run1023", 3, 1023, 1, 0, 20);
    tgtFreq = 10'd1023;
    runReq  = 1'b1;
    drain(6000);
    push_exp("max_dn_entry", 4, 1023, 0, 0, 0);
    push_exp("max_dn1019", 4, 1019, 0, 0, 0);
    for (int v = 1015; v >= 19; v -= 4) push_exp("max_dn", 4, v, 0, 0, 20);
    push_exp("max_idle", 0, 16, 0, 0, 20);
    runReq = 1'b0;
    drain(6000);

    // Asynchronous reset in the middle of a ramp at 32.
    push_exp("rst_start", 1, 16, 0, 0, 0);
    push_exp("rst_up_entry", 2, 16, 0, 0, 0);
    push_exp("rst_up20", 2, 20, 0, 0, 10);
    push_exp("rst_up24", 2, 24, 0, 0, 20);
    push_exp("rst_up28", 2, 28, 0, 0, 20);
    push_exp("rst_up32", 2, 32, 0, 0, 20);
    tgtFreq = 10'd40;
    runReq  = 1'b1;
    drain(400);
    push_exp("mid_reset", 0, 16, 0, 0, 0);
    #2 nRst = 1'b0;
    repeat (3) @(posedge clk);
    runReq = 1'b0;
    #1 nRst = 1'b1;
    drain(10);

`ifdef MOTORO3_WDOG_EN
    // Pulses stop in RUN: fault 1001 cycles after the last pulse edge; restart needs runReq low first.
    push_exp("wd_start", 1, 16, 0, 0, 0);
    push_exp("wd_run", 3, 16, 1, 0, 0);
    tgtFreq = 10'd16;
    runReq  = 1'b1;
    drain(100);
    pulse_en = 1'b0;
    push_exp("wd_fault", 0, 16, 0, 1, 1001);
    drain(1500);
    repeat (30) @(posedge clk);
    #1;
    push_exp("wd_clear", 0, 16, 0, 0, 0);
    runReq = 1'b0;
    drain(20);
    push_exp("wd_restart", 1, 16, 0, 0, 0);
    push_exp("wd_rerun", 3, 16, 1, 0, 0);
    pulse_en = 1'b1;
    runReq   = 1'b1;
    drain(100);
    push_exp("wd_down", 4, 16, 0, 0, 0);
    push_exp("wd_idle", 0, 16, 0, 0, 1);
    runReq = 1'b0;
    drain(100);
`endif

    repeat (30) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
